core_axi_lite_master: RTL

CORE_AXI_LITE_MASTER -- requirements
Module: core_axi_lite_master

---
 rtl/axi_lite_pkg.sv | 27 ++
 rtl/core_axi_lite_master.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite definitions: response codes and master FSM state encoding.
package axi_lite_pkg;

    // AXI response codes carried on BRESP / RRESP
    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_e;

    // Master transaction FSM; one transaction in flight at a time
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4,
        RESP  = 3'd5
    } state_e;

    // True for any response other than OKAY
    function automatic logic resp_is_err(input logic [1:0] resp);
        return axi_resp_e'(resp) != OKAY;
    endfunction

endpackage

// File: rtl/core_axi_lite_master.sv
// Core-side request/response port bridged to a single-outstanding AXI-lite
// master. Requests are latched on acceptance and replayed unmodified onto the
// bus; the response is held until the core takes it.
module core_axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 64   // 32 or 64
) (
    input  logic                            clk,
    input  logic                            rstn,
    // core request
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_we,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   req_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] req_wstrb,
    // core response
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   resp_rdata,
    output logic                            resp_err,
    // AW
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_awaddr,
    output logic                            m_awvalid,
    input  logic                            m_awready,
    // W
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_wstrb,
    output logic                            m_wvalid,
    input  logic                            m_wready,
    // B
    input  logic [1:0]                      m_bresp,
    input  logic                            m_bvalid,
    output logic                            m_bready,
    // AR
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_araddr,
    output logic                            m_arvalid,
    input  logic                            m_arready,
    // R
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]                      m_rresp,
    input  logic                            m_rvalid,
    output logic                            m_rready
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;

    state_e          r_state;
    logic            r_req_ready;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [SW-1:0]   r_wstrb;
    logic            r_awvalid;
    logic            r_wvalid;
    logic            r_bready;
    logic            r_arvalid;
    logic            r_rready;
    logic            r_resp_valid;
    logic            r_resp_err;
    logic [DW-1:0]   r_rdata;

    // Handshake on each write channel completes in this cycle (or already did)
    logic            w_aw_done;
    logic            w_w_done;

    assign w_aw_done = !r_awvalid || m_awready;
    assign w_w_done  = !r_wvalid  || m_wready;

    // Transaction FSM; every output it owns is a flop so nothing glitches on the bus
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // ready comes up one cycle after reset release
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_wstrb     <= req_wstrb;
                        if (req_we) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= WADDR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= RADDR;
                        end
                    end
                end
                WADDR: begin
                    // AW and W retire independently, in any order
                    if (m_awready) r_awvalid <= 1'b0;
                    if (m_wready)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= WRESP;
                    end
                end
                WRESP: begin
                    if (m_bvalid) begin
                        r_bready     <= 1'b0;
                        r_resp_err   <= resp_is_err(m_bresp);
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end
                end
                RADDR: begin
                    if (m_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RDATA;
                    end
                end
                RDATA: begin
                    // data is forwarded even when the slave flags an error
                    if (m_rvalid) begin
                        r_rready     <= 1'b0;
                        r_rdata      <= m_rdata;
                        r_resp_err   <= resp_is_err(m_rresp);
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    // req_ready rises only next cycle, so no back-to-back accept
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    // writes return zero data; read data register is left untouched by writes
    assign resp_rdata = r_we ? '0 : r_rdata;

    assign m_awaddr   = r_addr;
    assign m_awvalid  = r_awvalid;
    assign m_wdata    = r_wdata;
    assign m_wstrb    = r_wstrb;
    assign m_wvalid   = r_wvalid;
    assign m_bready   = r_bready;
    assign m_araddr   = r_addr;
    assign m_arvalid  = r_arvalid;
    assign m_rready   = r_rready;

endmodule
